// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch controller:
//   - state_t      : fetch sequencing states (IDLE, REQ, WAIT, HOLD)
//   - pc_sel_t     : next-PC source selector (hold / +4 / redirect target)
//   - NOP_INSTR_DEFAULT : addi x0,x0,0, shown to decode when nothing is valid
//   - RESET_PC_DEFAULT  : default PC after reset
//   - pc_plus4()   : 32-bit wrapping sequential-PC helper
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Sequential PC; wraps from 0xFFFF_FFFC to 0x0000_0000.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pc
// PC register with next-PC selection for the fetch controller.
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset, loads RESET_VAL
//   sel    in   2  next-PC source (pc_sel_t: hold / +4 / target)
//   target in  32  redirect target, used when sel = PC_TARGET
//   pc     out 32  current fetch PC
// -----------------------------------------------------------------------------
module fetch_ctrl_pc
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // Next-PC mux; target alignment is deliberately not checked.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_HOLD:   pc_next = pc;
      PC_INC:    pc_next = pc_plus4(pc);
      PC_TARGET: pc_next = target;
      default:   pc_next = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VAL;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// IF-stage sequencing controller. Issues one request at a time to a
// multi-cycle instruction memory (req/gnt then rvalid), presents the returned
// instruction to decode with valid/ready, and applies EX redirects, dropping
// the single response that was fetched on the wrong path.
//
// Optional feature macro: FETCH_CTRL_PERF_EN adds two wrapping 32-bit
// performance counters (accepted instructions, discarded/flushed ones).
//
// Ports:
//   i_clk            in   1  clock
//   i_rst            in   1  synchronous active-high reset
//   i_pc_src_EX      in   1  redirect request from EX
//   i_pc_target_EX   in  32  redirect target
//   o_imem_req       out  1  fetch request
//   o_imem_addr      out 32  fetch address
//   i_imem_gnt       in   1  request accepted this cycle
//   i_imem_rvalid    in   1  response valid
//   i_imem_rdata     in  32  response instruction
//   o_valid_F        out  1  instruction valid to decode
//   i_ready_D        in   1  decode accepts this cycle
//   o_pc_F           out 32  PC of presented instruction
//   o_pc_plus4_F     out 32  o_pc_F + 4 (wrapping)
//   o_instr_F        out 32  instruction, NOP_INSTR when not valid
//   o_perf_fetch_cnt out 32  (FETCH_CTRL_PERF_EN) instructions accepted
//   o_perf_kill_cnt  out 32  (FETCH_CTRL_PERF_EN) responses dropped + flushes
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pc_src_EX,
  input  logic [31:0] i_pc_target_EX,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid_F,
  input  logic        i_ready_D,
  output logic [31:0] o_pc_F,
  output logic [31:0] o_pc_plus4_F,
  output logic [31:0] o_instr_F
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_kill_cnt
`endif
);

  state_t      state, state_next;
  logic        kill, kill_next;
  logic        valid, valid_next;
  logic [31:0] instr, instr_next;
  logic [31:0] pc_out, pc_out_next;
  logic [1:0]  pc_sel;
  logic [31:0] pc;
  logic        fetch_evt;
  logic        kill_evt;

  fetch_ctrl_pc #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk    (i_clk),
    .rst    (i_rst),
    .sel    (pc_sel),
    .target (i_pc_target_EX),
    .pc     (pc)
  );

  // Next-state, kill flag, output-register and next-PC decisions.
  // A redirect wins over every other event in the same cycle.
  always_comb begin
    state_next  = state;
    kill_next   = kill;
    valid_next  = valid;
    instr_next  = instr;
    pc_out_next = pc_out;
    pc_sel      = PC_HOLD;
    fetch_evt   = 1'b0;
    kill_evt    = 1'b0;

    if (i_pc_src_EX) begin
      pc_sel = PC_TARGET;
    end else begin
      pc_sel = PC_HOLD;
    end

    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (i_imem_gnt) begin
          state_next = WAIT;
          // A request accepted alongside a redirect fetches the old path.
          kill_next  = i_pc_src_EX;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          if (i_pc_src_EX || kill) begin
            // Wrong-path response: drop it and refetch at pc (the target).
            state_next = REQ;
            kill_next  = 1'b0;
            kill_evt   = 1'b1;
          end else begin
            state_next  = HOLD;
            valid_next  = 1'b1;
            instr_next  = i_imem_rdata;
            pc_out_next = pc;
          end
        end else begin
          // Only the one outstanding response is ever stale, so a second
          // redirect here just moves pc and leaves kill set.
          if (i_pc_src_EX) begin
            kill_next = 1'b1;
          end else begin
            kill_next = kill;
          end
        end
      end
      HOLD: begin
        if (i_pc_src_EX) begin
          state_next = REQ;
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          kill_evt   = 1'b1;
        end else if (i_ready_D) begin
          state_next = REQ;
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          pc_sel     = PC_INC;
          fetch_evt  = 1'b1;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, kill flag and decode-facing output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      kill   <= 1'b0;
      valid  <= 1'b0;
      instr  <= NOP_INSTR;
      pc_out <= RESET_PC;
    end else begin
      state  <= state_next;
      kill   <= kill_next;
      valid  <= valid_next;
      instr  <= instr_next;
      pc_out <= pc_out_next;
    end
  end

  assign o_imem_req   = (state == REQ);
  assign o_imem_addr  = pc;
  assign o_valid_F    = valid;
  assign o_instr_F    = instr;
  assign o_pc_F       = pc_out;
  assign o_pc_plus4_F = pc_plus4(pc_out);

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;

  // Wrapping event counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_kill_cnt  <= 32'd0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, fetch_evt};
      perf_kill_cnt  <= perf_kill_cnt + {31'd0, kill_evt};
    end
  end

  assign o_perf_fetch_cnt = perf_fetch_cnt;
  assign o_perf_kill_cnt  = perf_kill_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl: a reactive instruction-memory responder with
// programmable gnt/rvalid delays, a transaction-level expectation model checked
// every cycle, and hand-computed literal checks at the interesting cycles.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'd0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        valid;
  logic        ready = 1'b1;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic [31:0] instr_f;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_kill;
`endif

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pc_src_EX    (redirect),
    .i_pc_target_EX (target),
    .o_imem_req     (req),
    .o_imem_addr    (addr),
    .i_imem_gnt     (gnt),
    .i_imem_rvalid  (rvalid),
    .i_imem_rdata   (rdata),
    .o_valid_F      (valid),
    .i_ready_D      (ready),
    .o_pc_F         (pc_f),
    .o_pc_plus4_F   (pc4_f),
    .o_instr_F      (instr_f)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .o_perf_fetch_cnt (perf_fetch),
    .o_perf_kill_cnt  (perf_kill)
`endif
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory contents seen by the responder.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0008: return 32'hDEAD_BEEF;
      default:       return {a[19:0], 12'h013};
    endcase
  endfunction

  // ---------------- memory responder (acts mid-cycle) ----------------
  int          gnt_delay = 0;
  int          rv_delay = 0;
  int          req_cnt = 0;
  int          rv_cnt = 0;
  int          gnt_count = 0;
  logic        pending = 1'b0;
  logic [31:0] last_gnt_addr = 32'd0;

  initial forever begin
    @(negedge clk);
    if (rvalid) rvalid = 1'b0;
    if (gnt) begin
      gnt = 1'b0;
      pending = 1'b1;
      rv_cnt = 0;
      req_cnt = 0;
    end
    if (pending) begin
      if (rv_cnt == rv_delay) begin
        rvalid = 1'b1;
        rdata = mem_word(last_gnt_addr);
        pending = 1'b0;
      end else begin
        rv_cnt++;
      end
    end else if (req) begin
      if (req_cnt == gnt_delay) begin
        gnt = 1'b1;
        last_gnt_addr = addr;
        gnt_count++;
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
  end

  // ---------------- transaction-level expectation model ----------------
  // Tracks: post-reset idle cycle, an outstanding granted request, whether
  // that response must be dropped, and whether an instruction is on offer.
  logic        model_ok = 1'b0;
  logic        m_idle, m_out, m_drop, m_have;
  logic [31:0] m_pc, m_last_pc, m_instr;
  logic [31:0] m_fetch, m_kill;
  logic        m_acc, m_resp;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_idle = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_have = 1'b0;
      m_pc = RST_PC; m_last_pc = RST_PC; m_instr = NOP;
      m_fetch = 32'd0; m_kill = 32'd0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_acc  = !m_idle && !m_out && !m_have && gnt;
      m_resp = m_out && rvalid;
      m_idle = 1'b0;
      if (redirect) begin
        m_pc = target;
        if (m_have) begin
          m_have = 1'b0;
          m_kill = m_kill + 32'd1;
        end
        if (m_acc) begin
          m_out = 1'b1; m_drop = 1'b1;
        end else if (m_resp) begin
          m_out = 1'b0; m_drop = 1'b0;
          m_kill = m_kill + 32'd1;
        end else if (m_out) begin
          m_drop = 1'b1;
        end
      end else begin
        if (m_have && ready) begin
          m_have = 1'b0;
          m_fetch = m_fetch + 32'd1;
          m_pc = m_pc + 32'd4;
        end
        if (m_acc) m_out = 1'b1;
        if (m_resp) begin
          m_out = 1'b0;
          if (m_drop) begin
            m_drop = 1'b0;
            m_kill = m_kill + 32'd1;
          end else begin
            m_have = 1'b1;
            m_instr = rdata;
            m_last_pc = m_pc;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic exp_req;
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      exp_req = !m_idle && !m_out && !m_have;
      check32("cmp_req", {31'd0, req}, {31'd0, exp_req});
      if (exp_req) check32("cmp_addr", addr, m_pc);
      check32("cmp_valid", {31'd0, valid}, {31'd0, m_have});
      check32("cmp_instr", instr_f, m_have ? m_instr : NOP);
      check32("cmp_pc", pc_f, m_last_pc);
      check32("cmp_pc4", pc4_f, m_last_pc + 32'd4);
`ifdef FETCH_CTRL_PERF_EN
      check32("cmp_perf_fetch", perf_fetch, m_fetch);
      check32("cmp_perf_kill", perf_kill, m_kill);
`endif
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  int gnt_snap;
  initial begin
    tick(3);
    check32("rst_req", {31'd0, req}, 32'd0);
    check32("rst_valid", {31'd0, valid}, 32'd0);
    check32("rst_instr", instr_f, 32'h0000_0013);
    check32("rst_pc", pc_f, 32'h0000_0000);
    check32("rst_pc4", pc4_f, 32'h0000_0004);
    rst = 1'b0;                                   // cycle 1: IDLE
    tick(1);                                      // cycle 2
    check32("first_req", {31'd0, req}, 32'd1);
    check32("first_addr", addr, 32'h0000_0000);
    tick(2);                                      // cycle 4
    check32("t1_valid", {31'd0, valid}, 32'd1);
    check32("t1_instr", instr_f, 32'h0050_0093);
    check32("t1_pc", pc_f, 32'h0000_0000);
    check32("t1_pc4", pc4_f, 32'h0000_0004);
    tick(1);                                      // cycle 5
    check32("t1_next_addr", addr, 32'h0000_0004);
    check32("t1_next_req", {31'd0, req}, 32'd1);
    ready = 1'b0;
    tick(1);                                      // cycle 6
    for (int i = 0; i < 5; i++) begin             // cycles 7..11
      tick(1);
      check32("hold_valid", {31'd0, valid}, 32'd1);
      check32("hold_instr", instr_f, 32'h0000_4013);
      check32("hold_pc", pc_f, 32'h0000_0004);
      check32("hold_noreq", {31'd0, req}, 32'd0);
    end
    tick(1);                                      // cycle 12
    check32("hold_valid_last", {31'd0, valid}, 32'd1);
    ready = 1'b1;
    rv_delay = 2;
    tick(1);                                      // cycle 13
    check32("t3_req_addr", addr, 32'h0000_0008);
    tick(1);                                      // cycle 14: WAIT
    redirect = 1'b1; target = 32'h0000_0100;
    tick(1);                                      // cycle 15
    redirect = 1'b0; target = 32'd0;
    check32("t3_wait_noreq", {31'd0, req}, 32'd0);
    tick(1);                                      // cycle 16: stale rvalid
    check32("t3_drop_rdata", rdata, 32'hDEAD_BEEF);
    check32("t3_drop_valid", {31'd0, valid}, 32'd0);
    tick(1);                                      // cycle 17
    check32("t3_post_valid", {31'd0, valid}, 32'd0);
    check32("t3_redir_addr", addr, 32'h0000_0100);
    check32("t3_redir_req", {31'd0, req}, 32'd1);
    rv_delay = 0;
    tick(2);                                      // cycle 19: HOLD
    check32("t3_valid", {31'd0, valid}, 32'd1);
    check32("t3_pc", pc_f, 32'h0000_0100);
    check32("t3_instr", instr_f, 32'h0010_0013);
    redirect = 1'b1; target = 32'h0000_0200; ready = 1'b1;
    gnt_delay = 4;
    gnt_snap = gnt_count;
    tick(1);                                      // cycle 20
    redirect = 1'b0; target = 32'd0; ready = 1'b0;
    check32("t4_flush_valid", {31'd0, valid}, 32'd0);
    check32("t4_flush_instr", instr_f, 32'h0000_0013);
    check32("t4_addr", addr, 32'h0000_0200);
`ifdef FETCH_CTRL_PERF_EN
    check32("t4_perf_kill", perf_kill, 32'd2);
    check32("t4_perf_fetch", perf_fetch, 32'd2);
`endif
    tick(1);                                      // cycle 21: 2nd ungranted cycle
    check32("t5_addr_stable", addr, 32'h0000_0200);
    redirect = 1'b1; target = 32'h0000_0040;
    tick(1);                                      // cycle 22
    redirect = 1'b0; target = 32'd0;
    check32("t5_addr_switch", addr, 32'h0000_0040);
    rv_delay = 1;
    tick(1);                                      // cycle 23
    check32("t5_addr_hold", addr, 32'h0000_0040);
    tick(1);                                      // cycle 24: granted
    check32("t5_req_at_gnt", {31'd0, req}, 32'd1);
    tick(1);                                      // cycle 25: WAIT
    check32("t5_gnt_addr", last_gnt_addr, 32'h0000_0040);
    check32("t5_gnt_count", gnt_count - gnt_snap, 32'd1);
    check32("t5_wait_noreq", {31'd0, req}, 32'd0);
    rst = 1'b1;
    gnt_delay = 0;
    tick(1);                                      // cycle 26: IDLE, late rvalid
    rst = 1'b0;
    check32("t6_rvalid_seen", {31'd0, rvalid}, 32'd1);
    check32("t6_valid", {31'd0, valid}, 32'd0);
    check32("t6_instr", instr_f, 32'h0000_0013);
    check32("t6_pc", pc_f, 32'h0000_0000);
    check32("t6_req", {31'd0, req}, 32'd0);
    tick(1);                                      // cycle 27
    check32("t6_first_req", {31'd0, req}, 32'd1);
    check32("t6_first_addr", addr, 32'h0000_0000);
    check32("t6_valid_after", {31'd0, valid}, 32'd0);
    redirect = 1'b1; target = 32'hFFFF_FFFC;
    rv_delay = 0;
    tick(1);                                      // cycle 28: stale response
    redirect = 1'b0; target = 32'd0;
    check32("t7_drop_valid", {31'd0, valid}, 32'd0);
    tick(1);                                      // cycle 29
    check32("t7_addr", addr, 32'hFFFF_FFFC);
    ready = 1'b1;
    tick(2);                                      // cycle 31
    check32("t7_valid", {31'd0, valid}, 32'd1);
    check32("t7_pc", pc_f, 32'hFFFF_FFFC);
    check32("t7_pc4_wrap", pc4_f, 32'h0000_0000);
    check32("t7_instr", instr_f, 32'hFFFF_C013);
    tick(1);                                      // cycle 32
    check32("t7_wrap_addr", addr, 32'h0000_0000);
    tick(1);                                      // cycle 33: rvalid + redirect
    redirect = 1'b1; target = 32'h0000_0080;
    tick(1);                                      // cycle 34
    redirect = 1'b0; target = 32'd0;
    check32("t8_valid", {31'd0, valid}, 32'd0);
    check32("t8_addr", addr, 32'h0000_0080);
`ifdef FETCH_CTRL_PERF_EN
    check32("t8_perf_kill", perf_kill, 32'd2);
    check32("t8_perf_fetch", perf_fetch, 32'd1);
`endif
    tick(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
